// File: rtl/exec_unit_mc.sv
// exec_unit_mc: multi-cycle execute unit.
//   ALU/branch ops complete one cycle after accept. M-extension multiply
//   (radix-2 shift-add) and divide (restoring) take XLEN+1 cycles.
//   Divide-by-zero and signed overflow finish one cycle after accept.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   request handshake (ready only while IDLE)
//   m_sel            0 = ALU/branch (operation), 1 = M op (m_op)
//   operand1/2       source operands, latched on accept
//   out_valid/ready  result handshake (valid only in DONE)
//   result, bcond    result value and branch-taken flag
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid keeps its payload stable until that
// edge; here result/bcond stay stable while out_valid && !out_ready.
// The FSM state is held in the signal named "state".
module exec_unit_mc #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            m_sel,
  input  logic [4:0]      operation,
  input  logic [2:0]      m_op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            bcond
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [SHW:0]    CNT_INIT = (SHW+1)'(XLEN);
  localparam logic [SHW:0]    CNT_ONE  = (SHW+1)'(1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_nxt;
  logic   accept;

  // Iteration registers
  logic [SHW:0]      cnt;
  logic [2*XLEN-1:0] mul_acc, mul_a;
  logic [XLEN-1:0]   mul_b;
  logic [XLEN-1:0]   div_q, div_r, div_d;
  logic              neg_q, neg_r;
  logic [1:0]        op_lo;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;

  // ---------------- single-cycle ALU / branch ----------------
  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] sum, alu_res;
  logic            lt_s, lt_u, eq, alu_bc;

  assign sh   = operand2[SHW-1:0];
  assign sum  = operand1 + operand2;
  assign lt_s = $signed(operand1) < $signed(operand2);
  assign lt_u = operand1 < operand2;
  assign eq   = operand1 == operand2;

  always_comb begin
    alu_res = '0;
    alu_bc  = 1'b0;
    if (!operation[4]) begin
      case (operation[3:0])
        4'b0000: alu_res = sum;
        4'b1000: alu_res = operand1 - operand2;
        4'b0100: alu_res = operand1 ^ operand2;
        4'b0110: alu_res = operand1 | operand2;
        4'b0111: alu_res = operand1 & operand2;
        4'b0010: alu_res = {{(XLEN-1){1'b0}}, lt_s};
        4'b0011: alu_res = {{(XLEN-1){1'b0}}, lt_u};
        4'b0001: alu_res = operand1 << sh;
        4'b0101: alu_res = operand1 >> sh;
        4'b1101: alu_res = $unsigned($signed(operand1) >>> sh);
        default: alu_res = '0;
      endcase
    end else begin
      case (operation[3:0])
        4'b0000: alu_bc  = eq;
        4'b0001: alu_bc  = !eq;
        4'b0100: alu_bc  = lt_s;
        4'b0101: alu_bc  = !lt_s;
        4'b0110: alu_bc  = lt_u;
        4'b0111: alu_bc  = !lt_u;
        4'b1001: alu_res = {sum[XLEN-1:1], 1'b0};
        4'b1000: alu_res = operand2;
        default: alu_res = '0;
      endcase
    end
  end

  // ---------------- M-op setup (evaluated in IDLE) ----------------
  // m_op[2]: divide group, m_op[1]: remainder, m_op[0]: unsigned (div).
  logic            sgn1, sgn2, neg1, neg2;
  logic [XLEN-1:0] mag1, mag2, spec_res;
  logic            div_zero, ovf, special;

  assign sgn1 = m_op[2] ? !m_op[0] : (m_op[1:0] == 2'b01 || m_op[1:0] == 2'b10);
  assign sgn2 = m_op[2] ? !m_op[0] : (m_op[1:0] == 2'b01);
  assign neg1 = sgn1 && operand1[XLEN-1];
  assign neg2 = sgn2 && operand2[XLEN-1];
  assign mag1 = neg1 ? (~operand1 + 1'b1) : operand1;
  assign mag2 = neg2 ? (~operand2 + 1'b1) : operand2;

  assign div_zero = (operand2 == '0);
  assign ovf      = !m_op[0] && (operand1 == MIN_NEG) && (operand2 == '1);
  assign special  = m_op[2] && (div_zero || ovf);
  assign spec_res = div_zero ? (m_op[1] ? operand1 : '1)
                             : (m_op[1] ? '0 : operand1);

  // ---------------- iteration datapath ----------------
  logic [2*XLEN-1:0] mul_acc_nxt, prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     r_sh, diff;
  logic              take;
  logic [XLEN-1:0]   div_q_nxt, div_r_nxt, q_fix, r_fix, div_res;

  assign mul_acc_nxt = mul_acc + (mul_b[0] ? mul_a : '0);
  assign prod        = neg_q ? (~mul_acc_nxt + 1'b1) : mul_acc_nxt;
  assign mul_res     = (op_lo == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Remainder stays below the divisor, so the shifted value fits XLEN+1 bits
  // and bit XLEN of the difference is the borrow.
  assign r_sh      = {div_r, div_q[XLEN-1]};
  assign diff      = r_sh - {1'b0, div_d};
  assign take      = !diff[XLEN];
  assign div_r_nxt = take ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
  assign div_q_nxt = {div_q[XLEN-2:0], take};
  assign q_fix     = neg_q ? (~div_q_nxt + 1'b1) : div_q_nxt;
  assign r_fix     = neg_r ? (~div_r_nxt + 1'b1) : div_r_nxt;
  assign div_res   = op_lo[1] ? r_fix : q_fix;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // The last iteration edge takes the counter from 1 to 0 and enters DONE,
  // with sign fixup folded into that same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) begin
        if (!m_sel)        state_nxt = S_DONE;
        else if (!m_op[2]) state_nxt = S_MUL;
        else if (special)  state_nxt = S_DONE;
        else               state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (cnt == CNT_ONE) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      mul_acc <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      div_q   <= '0;
      div_r   <= '0;
      div_d   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      op_lo   <= '0;
      result  <= '0;
      bcond   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_lo   <= m_op[1:0];
          cnt     <= CNT_INIT;
          neg_q   <= neg1 ^ neg2;
          neg_r   <= neg1;
          mul_acc <= '0;
          mul_a   <= {{XLEN{1'b0}}, mag1};
          mul_b   <= mag2;
          div_q   <= mag1;
          div_r   <= '0;
          div_d   <= mag2;
          if (!m_sel) begin
            result <= alu_res;
            bcond  <= alu_bc;
          end else begin
            bcond <= 1'b0;
            if (special) result <= spec_res;
          end
        end
        S_MUL: begin
          mul_acc <= mul_acc_nxt;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_ONE) result <= mul_res;
        end
        S_DIV: begin
          div_q <= div_q_nxt;
          div_r <= div_r_nxt;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_ONE) result <= div_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
// tb_exec_unit_mc: directed vector table plus hand-written multi-cycle
// sequences (backpressure, reset abort, XLEN=16 instance).
module tb_exec_unit_mc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 32-bit instance
  logic        in_valid, in_ready, m_sel, out_valid, out_ready, bcond;
  logic [4:0]  operation;
  logic [2:0]  m_op;
  logic [31:0] operand1, operand2, result;

  // 16-bit instance
  logic        in_valid_h, in_ready_h, m_sel_h, out_valid_h, out_ready_h, bcond_h;
  logic [4:0]  operation_h;
  logic [2:0]  m_op_h;
  logic [15:0] operand1_h, operand2_h, result_h;

  exec_unit_mc #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .m_sel(m_sel), .operation(operation), .m_op(m_op),
    .operand1(operand1), .operand2(operand2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .bcond(bcond)
  );

  exec_unit_mc #(.XLEN(16)) dut_h (
    .clk(clk), .rst(rst), .in_valid(in_valid_h), .in_ready(in_ready_h),
    .m_sel(m_sel_h), .operation(operation_h), .m_op(m_op_h),
    .operand1(operand1_h), .operand2(operand2_h), .out_valid(out_valid_h),
    .out_ready(out_ready_h), .result(result_h), .bcond(bcond_h)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        m_sel;
    logic [4:0]  op;
    logic [2:0]  mop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_bc;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ms, input logic [4:0] op, input logic [2:0] mop,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] er, input logic eb, input int el);
    vec_t v;
    v.m_sel = ms; v.op = op; v.mop = mop; v.a = a; v.b = b;
    v.exp_res = er; v.exp_bc = eb; v.exp_lat = el;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Latency counts cycles after the accept edge: 1 = valid right after it.
  task automatic run_op(input vec_t v, input string tag);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    check({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; m_sel = v.m_sel; operation = v.op; m_op = v.mop;
    operand1 = v.a; operand2 = v.b;
    exp_q.push_back(v.exp_res);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    operand1  = $urandom;
    operand2  = $urandom;
    operation = 5'($urandom);
    m_op      = 3'($urandom);
    m_sel     = 1'($urandom_range(0, 1));
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_result"}, result, exp_q.pop_front());
    check({tag, "_bcond"}, bcond, v.exp_bc);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (lat >= 100) pulse_reset();
  endtask

  task automatic run16(input logic [2:0] mop, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input int el, input string tag);
    int lat;
    check({tag, "_in_ready"}, in_ready_h, 1'b1);
    in_valid_h = 1'b1; m_sel_h = 1'b1; operation_h = 5'b0; m_op_h = mop;
    operand1_h = a; operand2_h = b;
    @(posedge clk); #1;
    in_valid_h = 1'b0;
    operand1_h = 16'($urandom);
    operand2_h = 16'($urandom);
    lat = 1;
    while (!out_valid_h && lat < 100) begin @(posedge clk); #1; lat++; end
    check({tag, "_latency"}, lat, el);
    check({tag, "_result"}, {16'h0, result_h}, {16'h0, er});
    check({tag, "_bcond"}, bcond_h, 1'b0);
    out_ready_h = 1'b1;
    @(posedge clk); #1;
    out_ready_h = 1'b0;
    if (lat >= 100) pulse_reset();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    int w;
    logic seen;

    vecs.push_back(mk(0, 5'b00000, 3'd0, 32'd7,        32'hFFFFFFFF, 32'd6,        0, 1));  // ADD
    vecs.push_back(mk(0, 5'b01000, 3'd0, 32'd5,        32'd7,        32'hFFFFFFFE, 0, 1));  // SUB
    vecs.push_back(mk(0, 5'b00100, 3'd0, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 0, 1));  // XOR
    vecs.push_back(mk(0, 5'b00110, 3'd0, 32'h0000000F, 32'h000000F0, 32'h000000FF, 0, 1));  // OR
    vecs.push_back(mk(0, 5'b00111, 3'd0, 32'h000000FF, 32'h0000000F, 32'h0000000F, 0, 1));  // AND
    vecs.push_back(mk(0, 5'b00010, 3'd0, 32'hFFFFFFFE, 32'd1,        32'd1,        0, 1));  // SLT
    vecs.push_back(mk(0, 5'b00011, 3'd0, 32'hFFFFFFFE, 32'd1,        32'd0,        0, 1));  // SLTU
    vecs.push_back(mk(0, 5'b00001, 3'd0, 32'd1,        32'h00000024, 32'h00000010, 0, 1));  // SLL, amount masked to 4
    vecs.push_back(mk(0, 5'b00101, 3'd0, 32'h80000000, 32'd31,       32'd1,        0, 1));  // SRL
    vecs.push_back(mk(0, 5'b01101, 3'd0, 32'h80000000, 32'd4,        32'hF8000000, 0, 1));  // SRA
    vecs.push_back(mk(0, 5'b10100, 3'd0, 32'hFFFFFFFE, 32'd1,        32'd0,        1, 1));  // BLT
    vecs.push_back(mk(0, 5'b10110, 3'd0, 32'hFFFFFFFE, 32'd1,        32'd0,        0, 1));  // BLTU
    vecs.push_back(mk(0, 5'b10000, 3'd0, 32'd5,        32'd5,        32'd0,        1, 1));  // BEQ
    vecs.push_back(mk(0, 5'b10101, 3'd0, 32'hFFFFFFFE, 32'd1,        32'd0,        0, 1));  // BGE
    vecs.push_back(mk(0, 5'b11001, 3'd0, 32'h00001001, 32'd4,        32'h00001004, 0, 1));  // JALR
    vecs.push_back(mk(0, 5'b11000, 3'd0, 32'hDEAD0000, 32'h12345000, 32'h12345000, 0, 1));  // LUI
    vecs.push_back(mk(0, 5'b01001, 3'd0, 32'd3,        32'd4,        32'd0,        0, 1));  // undefined ALU
    vecs.push_back(mk(0, 5'b10010, 3'd0, 32'd5,        32'd5,        32'd0,        0, 1));  // undefined branch
    vecs.push_back(mk(1, 5'b00000, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 0, 33)); // MULH
    vecs.push_back(mk(1, 5'b00000, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 33)); // MULHU
    vecs.push_back(mk(1, 5'b10000, 3'd0, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 0, 33)); // MUL
    vecs.push_back(mk(1, 5'b00000, 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0, 33)); // MULHSU
    vecs.push_back(mk(1, 5'b00000, 3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 33)); // DIV
    vecs.push_back(mk(1, 5'b00000, 3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 33)); // REM
    vecs.push_back(mk(1, 5'b00000, 3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 1));  // DIVU /0
    vecs.push_back(mk(1, 5'b00000, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 1));  // REM overflow
    vecs.push_back(mk(1, 5'b00000, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1));  // DIV overflow
    vecs.push_back(mk(1, 5'b00000, 3'd7, 32'd9,        32'd0,        32'd9,        0, 1));  // REMU /0
    vecs.push_back(mk(1, 5'b00000, 3'd7, 32'd100,      32'd7,        32'd2,        0, 33)); // REMU
    vecs.push_back(mk(1, 5'b00000, 3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 0, 33)); // DIVU

    in_valid = 0; m_sel = 0; operation = '0; m_op = '0; operand1 = '0; operand2 = '0;
    out_ready = 0;
    in_valid_h = 0; m_sel_h = 0; operation_h = '0; m_op_h = '0; operand1_h = '0;
    operand2_h = '0; out_ready_h = 0;

    // Reset held two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 32'd0);
    check("rst_bcond", bcond, 1'b0);
    check("rst_h_in_ready", in_ready_h, 1'b1);
    check("rst_h_out_valid", out_valid_h, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i], $sformatf("v%0d", i));

    // Backpressure: MUL 6 x 7 held in DONE for 5 cycles while a new request waits
    in_valid = 1'b1; m_sel = 1'b1; m_op = 3'd0; operand1 = 32'd6; operand2 = 32'd7;
    @(posedge clk); #1;
    m_sel = 1'b0; operation = 5'b00000; operand1 = 32'd1; operand2 = 32'd1;
    w = 1;
    while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
    check("bp_latency", w, 33);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_result_%0d", k), result, 32'd42);
      check($sformatf("bp_in_ready_%0d", k), in_ready, 1'b0);
      check($sformatf("bp_out_valid_%0d", k), out_valid, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_after_in_ready", in_ready, 1'b1);
    check("bp_after_out_valid", out_valid, 1'b0);

    // Reset at iteration 10 of a DIV aborts it
    in_valid = 1'b1; m_sel = 1'b1; m_op = 3'd4; operand1 = 32'd100; operand2 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_busy", in_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_result", result, 32'd0);
    check("abort_bcond", bcond, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 1'b0);
    run_op(mk(0, 5'b00000, 3'd0, 32'd10, 32'd20, 32'd30, 0, 1), "abort_recover");

    // XLEN = 16 instance
    run16(3'd0, 16'hFFFF, 16'hFFFF, 16'h0001, 17, "h_mul");
    run16(3'd3, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17, "h_mulhu");
    run16(3'd4, 16'hFFF9, 16'h0002, 16'hFFFD, 17, "h_div");
    run16(3'd5, 16'h1234, 16'h0000, 16'hFFFF, 1,  "h_divu0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_unit_mc.md
Name: exec_unit_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle execute block.
- Keeps the existing 5-bit ALU/branch operation encoding, generalised to XLEN bits.
- Adds an iterative RV32M-style multiply/divide path.
- Sits between decode/regfile read and writeback; uses a valid/ready handshake so the pipeline control can stall on long operations.

Parameters:
- XLEN, 32: operand/result width; must be a power of two, at least 8.
- SHW, $clog2(XLEN): shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request (high only in IDLE).
- m_sel  in  1  0 = ALU/branch op, 1 = M-extension op.
- operation  in  5  ALU/branch code. bit4 = 1 selects branch/JALR/LUI group. Low 4 bits follow the existing codes: ADD 0000, SUB 1000, XOR 0100, OR 0110, AND 0111, SLT 0010, SLTU 0011, SLL 0001, SRL 0101, SRA 1101, BEQ 0000, BNE 0001, BLT 0100, BGE 0101, BLTU 0110, BGEU 0111, JALR 1001, LUI 1000.
- m_op  in  3  used when m_sel = 1: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- operand1  in  XLEN  rs1 value.
- operand2  in  XLEN  rs2 value or immediate.
- out_valid  out  1  result/bcond valid.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  computed value.
- bcond  out  1  branch taken.

Behaviour:
- Reset: state = IDLE; in_ready = 1; out_valid = 0; result = 0; bcond = 0; all iteration registers = 0. Reset mid-operation aborts the operation; no result is produced.
- Accept condition: in_valid && in_ready. Operands and op are latched on accept; the inputs may change afterwards.
- States:
  - IDLE: on accept, go to MUL, DIV or DONE as below.
  - MUL: iterate, then go to DONE.
  - DIV: iterate, then go to DONE.
  - DONE: out_valid = 1. When out_ready = 1, go to IDLE. result and bcond hold stable while out_valid && !out_ready.
- ALU/branch ops (m_sel = 0): IDLE -> DONE; out_valid in the cycle after accept (latency 1).
  - Semantics match the single-cycle block: shifts use operand2[SHW-1:0]; SRA is arithmetic; SLT/BLT/BGE compare signed; JALR = (op1 + op2) with bit0 cleared; LUI = operand2.
  - bcond = 1 only for a satisfied branch compare; 0 for all other ops.
  - Branch ops produce result = 0.
  - Undefined codes produce result = 0, bcond = 0. The unit never drives X.
- MUL group:
  - Radix-2 shift-add over the absolute values, with XLEN iterations (1 per cycle).
  - Sign correction by the operand signedness: MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned.
  - MUL returns product[XLEN-1:0]; MULH* return product[2XLEN-1:XLEN].
  - Latency: out_valid exactly XLEN+1 cycles after accept.
- DIV group:
  - Restoring division on magnitudes, XLEN iterations, then sign fixup.
  - Quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1).
  - Latency XLEN+1, except for the special cases below.
- Special cases (decided in IDLE; go straight to DONE, latency 1):
  - Divisor = 0: DIV/DIVU return all-ones; REM/REMU return operand1.
  - Signed overflow (op1 = 100..0, op2 = all-ones): DIV returns operand1; REM returns 0.
- An iteration counter of SHW+1 bits counts XLEN down to 0. The exit to DONE happens when the counter reaches 0.
- bcond = 0 for all M ops.
- in_ready = 0 in MUL, DIV and DONE, so there is no back-to-back overlap. The earliest next accept is the cycle after a DONE handshake.

Test Plan:
- Reset hold for 2 cycles: in_ready = 1, out_valid = 0, result = 0. Then ADD 7 + 0xFFFFFFFF gives result = 6 one cycle after accept.
- BLT op1 = 0xFFFFFFFE, op2 = 1 gives bcond = 1. BLTU with the same operands gives bcond = 0. JALR 0x1001 + 4 gives result = 0x1004.
- MULH 0x80000000 x 0x80000000 gives 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF gives 0xFFFFFFFE. MUL 0xFFFFFFFF x 3 gives 0xFFFFFFFD. Each has out_valid at cycle 33.
- DIV -7 / 2 gives 0xFFFFFFFD (-3); REM -7 / 2 gives 0xFFFFFFFF (-1). Both at latency 33.
- DIVU 5 / 0 gives 0xFFFFFFFF at latency 1. REM 0x80000000 / 0xFFFFFFFF gives 0 at latency 1.
- Backpressure and abort:
  - Hold out_ready = 0 for 5 cycles: result stays stable and in_ready stays 0.
  - Assert rst at iteration 10 of a DIV: next cycle shows IDLE, in_ready = 1, out_valid = 0.
  - Repeat with XLEN = 16: MUL 0xFFFF x 0xFFFF gives 0x0001 at latency 17.
